// File: rtl/store_pkg.sv
// Shared types for the store buffer: access-size encoding and the queued entry layout.
// The entry is sized for the widest configuration; narrower builds leave the top bits constant.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } st_size_e;

    localparam int SB_AW_MAX   = 64;
    localparam int SB_XLEN_MAX = 64;
    localparam int SB_STRB_MAX = SB_XLEN_MAX / 8;

    typedef struct packed {
        logic [SB_AW_MAX-1:0]   waddr;
        logic [SB_XLEN_MAX-1:0] data;
        logic [SB_STRB_MAX-1:0] strb;
    } sb_entry_t;

    function automatic logic [7:0] size_mask(input st_size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places right-justified store data onto its byte lanes, builds the byte strobe,
// and flags misaligned or size-illegal stores.
module store_lane_align
    import store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  st_size_e          i_size,
    input  logic [2:0]        i_addr_lo,
    input  logic [XLEN-1:0]   i_data,
    output logic [XLEN-1:0]   o_lane_data,
    output logic [XLEN/8-1:0] o_strb,
    output logic              o_err
);

    localparam int BW  = XLEN / 8;
    localparam int OFF = $clog2(BW);

    logic [OFF-1:0] w_off;
    logic [BW-1:0]  w_mask;

    assign w_off       = i_addr_lo[OFF-1:0];
    assign w_mask      = BW'(size_mask(i_size));
    assign o_lane_data = i_data << {w_off, 3'b000};
    assign o_strb      = w_mask << w_off;

    // A double store is only meaningful on a 64-bit data path.
    always_comb begin
        o_err = 1'b0;
        case (i_size)
            SZ_H:    o_err = i_addr_lo[0];
            SZ_W:    o_err = (i_addr_lo[1:0] != 2'b00);
            SZ_D:    o_err = (XLEN == 32) || (i_addr_lo != 3'b000);
            default: o_err = 1'b0;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: aligns incoming stores, queues them, drains them to memory one
// per handshake, and flags loads whose word address matches any queued store.
module store_buffer
    import store_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 st_size,
    input  logic [AW-1:0]              st_addr,
    input  logic [XLEN-1:0]            st_data,
    output logic                       st_err,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [AW-1:0]              mem_addr,
    output logic [XLEN-1:0]            mem_wdata,
    output logic [XLEN/8-1:0]          mem_wstrb,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hazard,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int BW  = XLEN / 8;
    localparam int OFF = $clog2(BW);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    sb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_st_err;

    logic [XLEN-1:0] w_lane_data;
    logic [BW-1:0]   w_strb;
    logic            w_err;
    logic            w_accept;
    logic            w_enq;
    logic            w_deq;
    logic [DEPTH-1:0] w_hit;

    store_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_size      (st_size_e'(st_size)),
        .i_addr_lo   (st_addr[2:0]),
        .i_data      (st_data),
        .o_lane_data (w_lane_data),
        .o_strb      (w_strb),
        .o_err       (w_err)
    );

    assign st_ready  = (r_count < CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign mem_valid = !empty;
    assign count     = r_count;
    assign st_err    = r_st_err;

    assign w_accept  = st_valid && st_ready;
    assign w_enq     = w_accept && !w_err;
    assign w_deq     = mem_valid && mem_ready;

    assign mem_addr  = AW'(r_mem[r_head].waddr) << OFF;
    assign mem_wdata = XLEN'(r_mem[r_head].data);
    assign mem_wstrb = BW'(r_mem[r_head].strb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_st_err <= 1'b0;
        end else begin
            r_st_err <= w_accept && w_err;
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is never reset; validity comes purely from the pointers and count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{
                waddr: SB_AW_MAX'(st_addr >> OFF),
                data:  SB_XLEN_MAX'(w_lane_data),
                strb:  SB_STRB_MAX'(w_strb)
            };
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            logic [PW-1:0] w_rel;
            assign w_rel     = PW'(gi) - r_head;
            assign w_hit[gi] = ({1'b0, w_rel} < r_count) &&
                               (r_mem[gi].waddr == SB_AW_MAX'(ld_addr >> OFF));
        end
    endgenerate

    assign ld_hazard = |w_hit;

endmodule
